// File: rtl/ahb_dm_bridge.sv
// AHB-Lite responder driving the initiator side of a DM word-memory port.
// Sub-word writes merge HWDATA into DM_out in the access cycle (the DM port has no byte mask).
module ahb_dm_bridge #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned ADDR_BITS   = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic        DM_enable,
    output logic        DM_write,
    output logic [15:0] DM_address,
    output logic [31:0] DM_in,
    input  logic [31:0] DM_out
);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StAccess,
        StErr1,
        StErr2
    } state_e;

    localparam logic [1:0] WaitInit = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [17:0] addr_q;
    logic        write_q;
    logic [1:0]  size_q;

    logic        can_accept;
    logic        accept;
    logic        size_bad;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [3:0]  lanes;
    logic [31:0] merged;

    // Only the cycles that end a data phase (HREADYOUT high) may take a new address phase.
    assign can_accept = (state_q == StIdle) || (state_q == StAccess) || (state_q == StErr2);
    assign accept     = HSEL & HREADY & HTRANS[1] & can_accept;

    assign size_bad     = HSIZE > 3'd2;
    assign misaligned   = ((HSIZE == 3'd1) && HADDR[0]) || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign out_of_range = (HADDR >> ADDR_BITS) != 32'd0;
    assign req_err      = size_bad | misaligned | out_of_range;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            addr_q  <= 18'd0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= HADDR[17:0];
                write_q <= HWRITE;
                size_q  <= HSIZE[1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StAccess, StErr2: begin
                if (!accept) begin
                    state_d = StIdle;
                end else if (req_err) begin
                    state_d = StErr1;
                end else if (WAIT_STATES == 0) begin
                    state_d = StAccess;
                end else begin
                    state_d = StWait;
                    cnt_d   = WaitInit;
                end
            end
            StWait: begin
                if (cnt_q == 2'd0) begin
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StErr1: state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        lanes = 4'b1111;
        case (size_q)
            2'd0:    lanes = 4'b0001 << addr_q[1:0];
            2'd1:    lanes = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    always_comb begin
        merged = DM_out;
        for (int b = 0; b < 4; b++) begin
            if (lanes[b]) begin
                merged[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
    end

    always_comb begin
        HREADYOUT  = 1'b1;
        HRESP      = 1'b0;
        HRDATA     = 32'd0;
        DM_enable  = 1'b0;
        DM_write   = 1'b0;
        DM_address = 16'd0;
        DM_in      = 32'd0;
        unique case (state_q)
            StWait: HREADYOUT = 1'b0;
            StAccess: begin
                DM_enable  = 1'b1;
                DM_address = addr_q[17:2];
                if (write_q) begin
                    DM_write = 1'b1;
                    DM_in    = merged;
                end else begin
                    HRDATA = DM_out;
                end
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            StErr2: HRESP = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_dm_bridge.sv
// Directed bench: a zero-wait and a two-wait bridge, each backed by its own word memory.
module tb_ahb_dm_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] haddr = 32'd0;
    logic [1:0]  htrans = 2'd0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [31:0] hwdata = 32'd0;
    logic        hsel0 = 1'b0;
    logic        hsel2 = 1'b0;

    logic        hreadyout0, hresp0, dm_en0, dm_wr0;
    logic [31:0] hrdata0, dm_in0, dm_out0;
    logic [15:0] dm_addr0;
    logic        hreadyout2, hresp2, dm_en2, dm_wr2;
    logic [31:0] hrdata2, dm_in2, dm_out2;
    logic [15:0] dm_addr2;

    logic [31:0] mem0 [65536];
    logic [31:0] mem2 [65536];
    logic        pre_we0 = 1'b0;
    logic        pre_we2 = 1'b0;
    logic [15:0] pre_addr = 16'd0;
    logic [31:0] pre_data = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ahb_dm_bridge #(.WAIT_STATES(0), .ADDR_BITS(18)) dut0 (
        .clk(clk), .rst(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hreadyout0), .HREADYOUT(hreadyout0),
        .HRESP(hresp0), .HRDATA(hrdata0), .DM_enable(dm_en0), .DM_write(dm_wr0),
        .DM_address(dm_addr0), .DM_in(dm_in0), .DM_out(dm_out0)
    );

    ahb_dm_bridge #(.WAIT_STATES(2), .ADDR_BITS(18)) dut2 (
        .clk(clk), .rst(rst), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hreadyout2), .HREADYOUT(hreadyout2),
        .HRESP(hresp2), .HRDATA(hrdata2), .DM_enable(dm_en2), .DM_write(dm_wr2),
        .DM_address(dm_addr2), .DM_in(dm_in2), .DM_out(dm_out2)
    );

    assign dm_out0 = mem0[dm_addr0];
    assign dm_out2 = mem2[dm_addr2];

    always @(posedge clk) begin
        if (pre_we0) mem0[pre_addr] <= pre_data;
        else if (dm_en0 && dm_wr0) mem0[dm_addr0] <= dm_in0;
        if (pre_we2) mem2[pre_addr] <= pre_data;
        else if (dm_en2 && dm_wr2) mem2[dm_addr2] <= dm_in2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic bus(input logic s0, input logic s2, input logic [1:0] tr,
                       input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel0  = s0;
        hsel2  = s2;
        htrans = tr;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 3'd0);
    endtask

    task automatic preload(input logic which2, input logic [15:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we0  = !which2;
        pre_we2  = which2;
        step();
        pre_we0 = 1'b0;
        pre_we2 = 1'b0;
    endtask

    // Two-cycle ERROR response on the zero-wait bridge, with no memory strobe.
    task automatic err_seq(input string tag, input logic [31:0] a, input logic w,
                           input logic [2:0] sz);
        step();
        bus(1'b1, 1'b0, 2'd2, a, w, sz);
        step();
        idle();
        sample();
        check({tag, "_e1_rdy"}, 32'(hreadyout0), 32'd0);
        check({tag, "_e1_resp"}, 32'(hresp0), 32'd1);
        check({tag, "_e1_en"}, 32'(dm_en0), 32'd0);
        check({tag, "_e1_wr"}, 32'(dm_wr0), 32'd0);
        step();
        sample();
        check({tag, "_e2_rdy"}, 32'(hreadyout0), 32'd1);
        check({tag, "_e2_resp"}, 32'(hresp0), 32'd1);
        check({tag, "_e2_wr"}, 32'(dm_wr0), 32'd0);
        step();
        sample();
        check({tag, "_after_resp"}, 32'(hresp0), 32'd0);
    endtask

    initial begin
        idle();
        repeat (2) sample();
        check("rst_rdy", 32'(hreadyout0), 32'd1);
        check("rst_resp", 32'(hresp0), 32'd0);
        check("rst_rdata", hrdata0, 32'd0);
        check("rst_en", 32'(dm_en0), 32'd0);
        check("rst_wr", 32'(dm_wr0), 32'd0);
        check("rst_addr", 32'(dm_addr0), 32'd0);
        check("rst_din", dm_in0, 32'd0);
        check("rst_rdy2", 32'(hreadyout2), 32'd1);
        rst = 1'b1;

        // T1: word write then read back, zero-wait
        step();
        bus(1'b1, 1'b0, 2'd2, 32'h10, 1'b1, 3'd2);
        step();
        hwdata = 32'hDEADBEEF;
        bus(1'b1, 1'b0, 2'd2, 32'h10, 1'b0, 3'd2);
        sample();
        check("t1_wr_en", 32'(dm_en0), 32'd1);
        check("t1_wr_wr", 32'(dm_wr0), 32'd1);
        check("t1_wr_addr", 32'(dm_addr0), 32'h4);
        check("t1_wr_din", dm_in0, 32'hDEADBEEF);
        check("t1_wr_rdy", 32'(hreadyout0), 32'd1);
        step();
        idle();
        sample();
        check("t1_rd_data", hrdata0, 32'hDEADBEEF);
        check("t1_rd_addr", 32'(dm_addr0), 32'h4);
        check("t1_rd_wr", 32'(dm_wr0), 32'd0);
        check("t1_rd_rdy", 32'(hreadyout0), 32'd1);
        step();
        bus(1'b1, 1'b0, 2'd1, 32'h10, 1'b1, 3'd2);
        sample();
        check("t1_idle_rdata", hrdata0, 32'd0);
        step();
        idle();
        sample();
        check("t1_busy_en", 32'(dm_en0), 32'd0);
        check("t1_busy_rdy", 32'(hreadyout0), 32'd1);

        // T2: sub-word read-modify-write
        preload(1'b0, 16'h4, 32'h11223344);
        bus(1'b1, 1'b0, 2'd2, 32'h13, 1'b1, 3'd0);
        step();
        hwdata = 32'hA5123456;
        bus(1'b1, 1'b0, 2'd2, 32'h10, 1'b1, 3'd1);
        sample();
        check("t2_byte3_din", dm_in0, 32'hA5223344);
        step();
        hwdata = 32'h5555CAFE;
        bus(1'b1, 1'b0, 2'd2, 32'h12, 1'b1, 3'd1);
        sample();
        check("t2_half_lo_din", dm_in0, 32'hA522CAFE);
        step();
        hwdata = 32'h77881111;
        bus(1'b1, 1'b0, 2'd2, 32'h10, 1'b0, 3'd2);
        sample();
        check("t2_half_hi_din", dm_in0, 32'h7788CAFE);
        step();
        idle();
        sample();
        check("t2_rd_data", hrdata0, 32'h7788CAFE);
        step();
        sample();
        check("t2_mem", mem0[4], 32'h7788CAFE);
        check("t2_idle_rdata", hrdata0, 32'd0);

        // T3/T4: error responses
        err_seq("t3_misal_word", 32'h2, 1'b1, 3'd2);
        err_seq("t4_range", 32'h0004_0000, 1'b0, 3'd2);
        err_seq("t4_size3", 32'h0, 1'b0, 3'd3);
        err_seq("t4_half_odd", 32'h11, 1'b1, 3'd1);
        check("t4_mem0", mem0[0], 32'd0);
        check("t4_mem4", mem0[4], 32'h7788CAFE);

        // T5: two wait states, read latency and back-to-back write->read
        preload(1'b1, 16'h8, 32'hCAFEF00D);
        bus(1'b0, 1'b1, 2'd2, 32'h20, 1'b0, 3'd2);
        step();
        idle();
        sample();
        check("t5_w1_rdy", 32'(hreadyout2), 32'd0);
        check("t5_w1_en", 32'(dm_en2), 32'd0);
        step();
        sample();
        check("t5_w2_rdy", 32'(hreadyout2), 32'd0);
        step();
        sample();
        check("t5_acc_rdy", 32'(hreadyout2), 32'd1);
        check("t5_acc_data", hrdata2, 32'hCAFEF00D);
        check("t5_acc_addr", 32'(dm_addr2), 32'h8);
        step();
        bus(1'b0, 1'b1, 2'd2, 32'h24, 1'b1, 3'd2);
        step();
        hwdata = 32'h0BADC0DE;
        bus(1'b0, 1'b1, 2'd2, 32'h24, 1'b0, 3'd2);
        sample();
        check("t5_bw_w1_rdy", 32'(hreadyout2), 32'd0);
        check("t5_bw_w1_wr", 32'(dm_wr2), 32'd0);
        step();
        sample();
        check("t5_bw_w2_rdy", 32'(hreadyout2), 32'd0);
        step();
        sample();
        check("t5_bw_wr", 32'(dm_wr2), 32'd1);
        check("t5_bw_din", dm_in2, 32'h0BADC0DE);
        step();
        idle();
        sample();
        check("t5_bw_rw1_rdy", 32'(hreadyout2), 32'd0);
        check("t5_bw_rw1_rdata", hrdata2, 32'd0);
        step();
        step();
        sample();
        check("t5_bw_rd_data", hrdata2, 32'h0BADC0DE);

        // T6: reset during the wait of a write
        step();
        preload(1'b1, 16'hA, 32'h12345678);
        bus(1'b0, 1'b1, 2'd2, 32'h28, 1'b1, 3'd2);
        step();
        hwdata = 32'hFFFFFFFF;
        idle();
        sample();
        check("t6_wait_rdy", 32'(hreadyout2), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_rdy", 32'(hreadyout2), 32'd1);
        check("t6_rst_resp", 32'(hresp2), 32'd0);
        check("t6_rst_en", 32'(dm_en2), 32'd0);
        check("t6_rst_wr", 32'(dm_wr2), 32'd0);
        check("t6_rst_addr", 32'(dm_addr2), 32'd0);
        check("t6_rst_din", dm_in2, 32'd0);
        sample();
        rst = 1'b1;
        repeat (3) step();
        check("t6_mem", mem2[10], 32'h12345678);
        bus(1'b0, 1'b1, 2'd2, 32'h28, 1'b0, 3'd2);
        step();
        idle();
        step();
        step();
        sample();
        check("t6_rd_data", hrdata2, 32'h12345678);
        check("t6_rd_resp", 32'(hresp2), 32'd0);
        check("t6_rd_rdy", 32'(hreadyout2), 32'd1);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
